// File: rtl/multi_clock_div.sv
// multi_clock_div: multi-channel run-time programmable 50% clock divider; define MULTI_CLOCK_DIV_TICK_EN to build tick strobes
module multi_clock_div #(
   parameter  int CHANNELS    = 4,
   parameter  int WIDTH       = 32,
   parameter  int DEFAULT_DIV = 50,
   localparam int CH_W        = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                restart,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [WIDTH-1:0]    wr_div,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] pend
);
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [WIDTH-1:0] cnt_q, cnt_d, div_cur_q, div_cur_d, div_pend_q, div_pend_d;
      logic             out_q, out_d, pend_q, pend_d;
      logic             running, hit, wr_hit, apply;
      // next state: the pending divisor only lands at a falling toggle, on restart, or on an idle channel
      always_comb begin
         running    = div_cur_q != '0;
         hit        = running && (cnt_q == div_cur_q - 1'b1);
         wr_hit     = wr_en && (wr_ch == CH_W'(g));
         apply      = pend_q && (restart || !running || (hit && out_q));
         cnt_d      = (restart || hit || !running) ? '0 : cnt_q + 1'b1;
         out_d      = !restart && running && (out_q ^ hit);
         div_cur_d  = apply ? div_pend_q : div_cur_q;
         div_pend_d = wr_hit ? wr_div : div_pend_q;
         pend_d     = wr_hit || (pend_q && !apply);
      end
      // channel state registers
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_q      <= '0;
            div_cur_q  <= WIDTH'(DEFAULT_DIV);
            div_pend_q <= '0;
            out_q      <= 1'b0;
            pend_q     <= 1'b0;
         end else begin
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            out_q      <= out_d;
            pend_q     <= pend_d;
         end
      end
      assign clk_out[g] = out_q;
      assign pend[g]    = pend_q;
`ifdef MULTI_CLOCK_DIV_TICK_EN
      logic tick_q;
      // strobe registered alongside the rising output edge
      always_ff @(posedge clk or posedge reset) begin
         if (reset) tick_q <= 1'b0;
         else       tick_q <= !out_q && out_d;
      end
      assign tick[g] = tick_q;
`else
      assign tick[g] = 1'b0;
`endif
   end
endmodule

// File: tb/tb_multi_clock_div.sv
// tb_multi_clock_div: scoreboard bench for multi_clock_div against a down-counting reference model
module tb_multi_clock_div;
   localparam int CH  = 3;
   localparam int DEF = 50;
`ifdef MULTI_CLOCK_DIV_TICK_EN
   localparam bit TICK_EN = 1'b1;
`else
   localparam bit TICK_EN = 1'b0;
`endif

   typedef struct packed {
      logic [CH-1:0] o;
      logic [CH-1:0] t;
      logic [CH-1:0] p;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          restart = 1'b0;
   logic          wr_en = 1'b0;
   logic [1:0]    wr_ch = '0;
   logic [15:0]   wr_div = '0;
   logic [CH-1:0] clk_out, tick, pend;

   int unsigned m_rem [CH];
   int unsigned m_div [CH];
   int unsigned m_pdiv [CH];
   logic [CH-1:0] m_out, m_tick, m_pend;
   exp_t sb[$];
   int n_chk = 0;
   int n_fail = 0;
   int n = 0;

   multi_clock_div #(.CHANNELS(CH), .WIDTH(16), .DEFAULT_DIV(DEF)) dut (
      .clk(clk), .reset(reset), .restart(restart), .wr_en(wr_en), .wr_ch(wr_ch),
      .wr_div(wr_div), .clk_out(clk_out), .tick(tick), .pend(pend)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         m_rem[i]  = DEF;
         m_div[i]  = DEF;
         m_pdiv[i] = 0;
      end
      m_out  = '0;
      m_tick = '0;
      m_pend = '0;
   endtask

   // reference: m_rem counts edges remaining until the next toggle
   task automatic model_step(input logic rs, input logic we, input logic [1:0] wch, input logic [15:0] wd);
      for (int i = 0; i < CH; i++) begin
         logic ap, o;
         ap = 1'b0;
         o  = m_out[i];
         if (rs) begin
            o = 1'b0;
            m_rem[i] = m_div[i];
            ap = m_pend[i];
         end else if (m_div[i] == 0) begin
            o = 1'b0;
            ap = m_pend[i];
         end else begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
               o = !m_out[i];
               m_rem[i] = m_div[i];
               ap = m_out[i] && m_pend[i];
            end
         end
         if (ap) begin
            m_div[i]  = m_pdiv[i];
            m_rem[i]  = m_div[i];
            m_pend[i] = 1'b0;
            o = 1'b0;
         end
         m_tick[i] = TICK_EN && o && !m_out[i];
         m_out[i]  = o;
         if (we && int'(wch) == i) begin
            m_pdiv[i] = wd;
            m_pend[i] = 1'b1;
         end
      end
   endtask

   task automatic cyc(input logic rs, input logic we, input logic [1:0] ch, input logic [15:0] dv);
      exp_t e;
      restart = rs;
      wr_en   = we;
      wr_ch   = ch;
      wr_div  = dv;
      model_step(rs, we, ch, dv);
      sb.push_back('{o: m_out, t: m_tick, p: m_pend});
      @(posedge clk);
      #1;
      n++;
      e = sb.pop_front();
      check("clk_out", 32'(clk_out), 32'(e.o));
      check("tick", 32'(tick), 32'(e.t));
      check("pend", 32'(pend), 32'(e.p));
      @(negedge clk);
      restart = 1'b0;
      wr_en   = 1'b0;
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 2'd0, 16'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_clk_out", 32'(clk_out), 0);
      check("rst_tick", 32'(tick), 0);
      check("rst_pend", 32'(pend), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      n = 0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      run(49);
      check("pre_rise50", 32'(clk_out[0]), 0);
      run(1);
      check("rise50", 32'(clk_out[0]), 1);
      check("tick50", 32'(tick[0]), 32'(TICK_EN));
      run(1);
      check("tick51", 32'(tick[0]), 0);
      run(48);
      check("high99", 32'(clk_out[0]), 1);
      run(1);
      check("fall100", 32'(clk_out[0]), 0);
      run(60);
      cyc(1'b0, 1'b1, 2'd1, 16'd10);
      check("pend1_set", 32'(pend[1]), 1);
      cyc(1'b0, 1'b1, 2'd2, 16'd0);
      run(37);
      check("ch1_high199", 32'(clk_out[1]), 1);
      check("pend1_199", 32'(pend[1]), 1);
      run(1);
      check("ch1_fall200", 32'(clk_out[1]), 0);
      check("pend1_200", 32'(pend[1]), 0);
      check("pend2_200", 32'(pend[2]), 0);
      run(9);
      check("ch1_low209", 32'(clk_out[1]), 0);
      run(1);
      check("ch1_rise210", 32'(clk_out[1]), 1);
      run(10);
      check("ch1_fall220", 32'(clk_out[1]), 0);
      run(10);
      check("ch1_rise230", 32'(clk_out[1]), 1);
      check("ch2_off230", 32'(clk_out[2]), 0);
      cyc(1'b0, 1'b1, 2'd2, 16'd3);
      check("pend2_231", 32'(pend[2]), 1);
      run(1);
      check("pend2_232", 32'(pend[2]), 0);
      run(2);
      check("ch2_low234", 32'(clk_out[2]), 0);
      run(1);
      check("ch2_rise235", 32'(clk_out[2]), 1);
      run(3);
      check("ch2_fall238", 32'(clk_out[2]), 0);
      run(3);
      check("ch2_rise241", 32'(clk_out[2]), 1);
      cyc(1'b0, 1'b1, 2'd0, 16'd5);
      cyc(1'b0, 1'b1, 2'd1, 16'd7);
      run(69);
      cyc(1'b0, 1'b1, 2'd2, 16'd9);
      cyc(1'b1, 1'b1, 2'd2, 16'd4);
      check("restart_all_low", 32'(clk_out), 0);
      check("restart_pend2", 32'(pend[2]), 1);
      run(4);
      check("ch0_low318", 32'(clk_out[0]), 0);
      run(1);
      check("ch0_rise319", 32'(clk_out[0]), 1);
      check("ch1_low319", 32'(clk_out[1]), 0);
      run(2);
      check("ch1_rise321", 32'(clk_out[1]), 1);
      cyc(1'b0, 1'b1, 2'd0, 16'd4);
      cyc(1'b0, 1'b1, 2'd0, 16'd8);
      cyc(1'b0, 1'b1, 2'd3, 16'd9);
      check("pend_324", 32'(pend), 32'b100);
      run(7);
      check("ch0_low331", 32'(clk_out[0]), 0);
      run(1);
      check("ch0_rise332", 32'(clk_out[0]), 1);
      cyc(1'b0, 1'b1, 2'd1, 16'd20);
      run(5);
      do_reset();
      run(50);
      check("post_rst_rise50", 32'(clk_out[0]), 1);
      check("post_rst_pend", 32'(pend), 0);
      run(50);
      check("post_rst_fall100", 32'(clk_out[0]), 0);
      run(50);
      check("post_rst_rise150", 32'(clk_out[0]), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/multi_clock_div.md
# multi_clock_div

Multi-channel, run-time programmable clock divider. Generates `CHANNELS` independent 50%-duty divided clocks from one system clock. Each channel has a one-cycle tick strobe and a divisor that can be rewritten while running, without glitches. It sits between the board oscillator (50 MHz on DE-10) and the slow-clock consumers: display scan, debouncers and UART baud. It replaces the fixed, single-output divider.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent divider channels (1–16).
- `WIDTH`, 32: width of the counter and divisor per channel.
- `DEFAULT_DIV`, 50: half-period loaded into every channel at reset. 50 gives 500 kHz from 50 MHz.
- Localparam `CH_W` = max(1, clog2(`CHANNELS`)).

Ports:
- `clk` input, 1: system clock. All logic is on the rising edge.
- `reset` input, 1: asynchronous, active-high reset.
- `restart` input, 1: synchronous phase-align pulse for all channels.
- `wr_en` input, 1: divisor write strobe, one cycle per write.
- `wr_ch` input, `CH_W`: target channel of the write.
- `wr_div` input, `WIDTH`: new half-period. 0 disables the channel.
- `clk_out` output, `CHANNELS`: divided clocks.
- `tick` output, `CHANNELS`: one-cycle strobe on each `clk_out` rising edge.
- `pend` output, `CHANNELS`: a written divisor is waiting to be applied.

## Operation
- Per-channel state:
  - `cnt`: `WIDTH` bits.
  - `div_cur`: active half-period.
  - `div_pend`: pending divisor, with a pending flag.
  - output flop.
- Running channel (`div_cur` ≠ 0):
  - `cnt` increments every cycle.
  - When `cnt == div_cur-1`: `cnt` becomes 0 and `clk_out` toggles.
  - Output period is 2·`div_cur` cycles at exactly 50% duty.
  - `div_cur` = 1 gives clk/2.
- Disabled channel (`div_cur` = 0):
  - `cnt` is held at 0 and `clk_out` is held at 0.
  - `tick` stays at 0.
- Write:
  - `wr_en` with `wr_ch` < `CHANNELS` loads `div_pend[wr_ch]` and sets `pend[wr_ch]`.
  - Writes with `wr_ch` ≥ `CHANNELS` are ignored.
  - A second write before the apply overwrites the first (last write wins).
  - Writes are always accepted. There is no backpressure.
- Apply (glitch-free):
  - A pending divisor is applied on the cycle in which the channel's `clk_out` toggles 1→0, i.e. at the end of a full period.
  - A disabled channel applies it on the cycle after the write.
  - On apply: `div_cur` ← `div_pend`, `cnt` ← 0, `pend` clears, and `clk_out` stays 0.
  - The new period starts cleanly and no high phase is ever shortened.
  - Writing 0 to a running channel stops it low at the end of its current period.
- Restart:
  - `restart` high for one cycle forces every channel to `cnt` ← 0 and `clk_out` ← 0.
  - Every channel with `pend` set applies its pending divisor in the same cycle.
  - All channels then rise together `div_cur` cycles later (phase alignment).
- Simultaneous events:
  - Write and apply in the same cycle on one channel: the previously pending value is applied, the new write becomes pending and `pend` stays 1.
  - Write in the same cycle as `restart`: same rule. `restart` applies the old pending value and the new write stays pending.
  - `restart` has priority over the normal toggle and apply in that cycle.

## Timing
- Reset values, asynchronous and immediate:
  - `clk_out` = 0, `tick` = 0, `pend` = 0.
  - every `cnt` = 0, every `div_cur` = `DEFAULT_DIV`, every `div_pend` = 0.
- Edge counting after reset deassertion: counting starts on the first `clk` rising edge.
  - With `div_cur` = H, `clk_out` rises after edge H and falls after edge 2H.
  - The same applies after `restart`, counted from the edge that samples `restart`.
- `tick[i]` is registered and high for exactly the one cycle in which `clk_out[i]` first reads 1.
- `pend` is set in the cycle after the `wr_en` edge.
- `cnt` never exceeds `div_cur-1`, so there is no wrap-around. `WIDTH`-bit divisors up to 2^`WIDTH`−1 are legal.
- Reset mid-period discards all pending writes and returns to `DEFAULT_DIV`.

## Configuration
- `MULTI_CLOCK_DIV_TICK_EN` defined:
  - tick generation logic is compiled in and `tick` behaves as above.
- Not defined:
  - the `tick` port remains and is tied to 0.
  - no tick flops are synthesised.
  - all other behaviour is identical.

## Test plan
- Reset with defaults (`DEFAULT_DIV`=50), release reset:
  - `clk_out[0]` rises after edge 50 and falls after edge 100, at 50% duty, with period 100.
  - `tick[0]` is high for one cycle at edge 50.
- Running channel 1 at 50: write 10 mid high phase.
  - `pend[1]` = 1 until the next falling toggle.
  - Then `clk_out[1]` rises 10 cycles later with period 20.
  - No high phase shorter than 50 occurs before the switch.
- Write 0 to channel 2 while running:
  - `clk_out[2]` finishes its period, then stays 0.
  - Then write 3: `clk_out[2]` rises 3 cycles after the apply, with period 6.
- Channels at 5 and 7, pulse `restart` mid-period:
  - both outputs go to 0.
  - channel A rises 5 cycles later and channel B rises 7 cycles later, both from the same edge.
- Two writes (4, then 8) to channel 0 before apply, plus `wr_ch` = `CHANNELS`:
  - 8 is applied.
  - the out-of-range write changes nothing.
- Assert `reset` mid-period with a write pending:
  - all outputs are 0 immediately, without waiting for a clock.
  - after release, `pend` = 0 and the period is 2·`DEFAULT_DIV`.
